yarvi_dmem_responder: RTL

- Data-memory responder for the yarvi core's load/store path; the memory side of the core's LOAD/STORE accesses.
- Accepts one request at a time on a valid/ready handshake, inserts a programmable number of wait states, and performs RISC-V byte/half/word access with lane steering and sign/zero extension.
- Returns one response per request with backpressure; flags out-of-range, misaligned and illegal-funct3 accesses instead of halting simulation.

---
 rtl/yarvi_dmem_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/yarvi_dmem_responder.sv
// yarvi_dmem_responder: wait-stated data memory with RISC-V byte/half/word access over valid/ready
module yarvi_dmem_responder #(
  parameter int MEM_WORDS_LG2 = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_error
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t r_state;
  logic [3:0] r_cnt;
  logic r_write;
  logic [2:0] r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic r_resp_valid;
  logic [31:0] r_rdata;
  logic r_error;
  logic [31:0] r_mem [0:(1<<MEM_WORDS_LG2)-1];
  logic [MEM_WORDS_LG2-1:0] w_idx;
  logic [1:0] w_lane;
  logic [4:0] w_sh;
  logic w_oor;
  logic w_mis;
  logic w_bad;
  logic w_err;
  logic w_access;
  logic w_commit;
  logic [31:0] w_word;
  logic [15:0] w_low;
  logic [31:0] w_load;
  logic [31:0] w_wdata_sh;
  logic [3:0] w_mask;
  logic [31:0] w_bits;
  assign w_idx = r_addr[MEM_WORDS_LG2+1:2];
  assign w_lane = r_addr[1:0];
  assign w_sh = {w_lane, 3'b000};
  assign w_oor = |r_addr[31:MEM_WORDS_LG2+2];
  assign w_mis = (r_funct3[1:0] == 2'd1 && r_addr[0]) || (r_funct3[1:0] == 2'd2 && |w_lane);
  assign w_bad = r_write ? (r_funct3 >= 3'd3) : (r_funct3 == 3'd3 || r_funct3[2:1] == 2'b11);
  assign w_err = w_oor || w_mis || w_bad;
  assign w_access = r_state == S_WAIT && r_cnt == 4'd0;
  assign w_commit = w_access && reset && r_write && !w_err;
  assign w_word = r_mem[w_idx];
  assign w_low = 16'(w_word >> w_sh);
  assign w_load = r_funct3[1:0] == 2'd0 ? {{24{~r_funct3[2] & w_low[7]}}, w_low[7:0]} :
                  r_funct3[1:0] == 2'd1 ? {{16{~r_funct3[2] & w_low[15]}}, w_low} : w_word;
  assign w_wdata_sh = r_wdata << w_sh;
  assign w_mask = (r_funct3[1:0] == 2'd0 ? 4'h1 : r_funct3[1:0] == 2'd1 ? 4'h3 : 4'hF) << w_lane;
  assign w_bits = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
  assign o_req_ready = reset && r_state == S_IDLE;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_rdata;
  assign o_resp_error = r_error;
  // request/wait/response sequencing; the access result is captured as the FSM enters RESP
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt <= 4'd0;
      r_write <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
      r_resp_valid <= 1'b0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_write <= i_req_write;
          r_funct3 <= i_req_funct3;
          r_addr <= i_req_addr;
          r_wdata <= i_req_wdata;
          r_cnt <= 4'(WAIT_STATES);
          r_state <= S_WAIT;
        end
        S_WAIT: if (r_cnt == 4'd0) begin
          r_state <= S_RESP;
          r_resp_valid <= 1'b1;
          r_error <= w_err;
          r_rdata <= (w_err || r_write) ? 32'd0 : w_load;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_RESP: if (i_resp_ready) begin
          r_state <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_rdata <= 32'd0;
          r_error <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // byte-masked store commit; memory is deliberately outside reset
  always_ff @(posedge clock) begin
    if (w_commit) r_mem[w_idx] <= (w_word & ~w_bits) | (w_wdata_sh & w_bits);
  end
endmodule
